// File: rtl/fft_frame_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_packer_if : sample input, FFT config stream and FFT data stream.
// Revision 1.0
// ---------------------------------------------------------------------------
interface fft_frame_packer_if #(
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              start;
  logic [15:0]       cfg_tdata;
  logic              cfg_tvalid;
  logic              cfg_tready;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              busy;
  logic              overflow;

  modport master (
    input  din, din_valid, start, cfg_tready, m_tready,
    output cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, busy, overflow
  );

  modport slave (
    output din, din_valid, start, cfg_tready, m_tready,
    input  cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_packer : configures the FFT core, then packs FRAME_LEN samples
//                    into complex words through a small FWFT FIFO.
// Revision 1.0
// ---------------------------------------------------------------------------
module fft_frame_packer #(
  parameter int          DATA_W     = 14,
  parameter int          FRAME_LEN  = 1024,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CFG_WORD   = 16'h0001
) (
  input  logic               sclk,
  input  logic               rst_n,
  fft_frame_packer_if.master bus
);
  localparam int                CNT_W     = $clog2(FRAME_LEN) + 1;
  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_RST     = 3'd0;
  localparam logic [2:0] S_CFG     = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_cfg_tvalid;
  logic             w_cfg_tvalid_nxt;
  logic             w_busy;

  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_try;
  logic             w_wr_en;
  logic             w_drop;
  logic             w_rd_en;
  logic             w_tlast;
  logic             w_start_frame;
  logic             w_last_wr;
  logic [15:0]      w_sample_ext;

  // Full is judged on the registered count, so a pop in the same cycle
  // cannot rescue a write that arrives while the FIFO is full.
  assign w_full        = (r_count == FIFO_FULL);
  assign w_empty       = (r_count == '0);
  assign w_wr_try      = (r_state == S_CAPTURE) && bus.din_valid;
  assign w_wr_en       = w_wr_try && !w_full;
  assign w_drop        = w_wr_try && w_full;
  assign w_rd_en       = !w_empty && bus.m_tready;
  assign w_tlast       = !w_empty && (r_rd_cnt == LAST_IDX);
  assign w_start_frame = (r_state == S_IDLE) && bus.start;
  assign w_last_wr     = w_wr_en && (r_wr_cnt == LAST_IDX);
  assign w_sample_ext  = 16'($signed(bus.din));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RST;
      r_cfg_tvalid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cfg_tvalid <= w_cfg_tvalid_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST:     w_next_state = S_CFG;
      S_CFG:     if (r_cfg_tvalid && bus.cfg_tready) w_next_state = S_IDLE;
      S_IDLE:    if (bus.start) w_next_state = S_CAPTURE;
      S_CAPTURE: if (w_last_wr) w_next_state = S_DRAIN;
      S_DRAIN:   if (w_rd_en && w_tlast) w_next_state = S_IDLE;
      default:   w_next_state = S_RST;
    endcase
  end

  // cfg_tvalid is registered: it trails entry into CFG by one edge.
  always_comb begin
    w_cfg_tvalid_nxt = (r_state == S_CFG) && !(r_cfg_tvalid && bus.cfg_tready);
    w_busy           = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  end

  always_ff @(posedge sclk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_sample_ext;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_en && !w_rd_en)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_wr_en && w_rd_en) r_count <= r_count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_frame) begin
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      if (w_rd_en && (r_rd_cnt != LAST_IDX)) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.cfg_tdata  = CFG_WORD;
  assign bus.cfg_tvalid = r_cfg_tvalid;
  assign bus.m_tvalid   = !w_empty;
  assign bus.m_tdata    = w_empty ? 32'h0000_0000 : {16'h0000, r_mem[r_rd_ptr]};
  assign bus.m_tlast    = w_tlast;
  assign bus.busy       = w_busy;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire
